rgb_axis_s2mm_packer: RTL and testbench

Transmit-side counterpart of the mm2s RGB path. Accepts the camera-side pixel stream (valid, iRed, iGreen, iBlue), which has no backpressure. Buffers the pixels in a first-word-fall-through FIFO and emits them as an AXI4-Stream master toward the VDMA s2mm write channel. Generates tuser (start of frame) and tlast (end of line) from internal x/y counters, and flags overflow when the sink stalls longer than the buffer can absorb.

---
 rtl/rgb_axis_s2mm_packer.sv | 142 ++++++++++++++
 tb/tb_rgb_axis_s2mm_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_axis_s2mm_packer.sv
// Camera pixel stream to AXI4-Stream master for the VDMA s2mm write channel.
// Buffers pixels in a FWFT FIFO with registered outputs, generates tuser/tlast framing, and counts drops.
module rgb_axis_s2mm_packer #(
    parameter int COLOR_W    = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic                          pixclk,
    input  logic                          reset,
    input  logic                          valid,
    input  logic [COLOR_W-1:0]            iRed,
    input  logic [COLOR_W-1:0]            iGreen,
    input  logic [COLOR_W-1:0]            iBlue,
    output logic                          m_axis_s2mm_tvalid,
    input  logic                          m_axis_s2mm_tready,
    output logic [DATA_W-1:0]             m_axis_s2mm_tdata,
    output logic                          m_axis_s2mm_tuser,
    output logic                          m_axis_s2mm_tlast,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PIX_W = 3 * COLOR_W;
    localparam int X_W   = $clog2(IMG_WIDTH > 1 ? IMG_WIDTH : 2);
    localparam int Y_W   = $clog2(IMG_HEIGHT > 1 ? IMG_HEIGHT : 2);

    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_HEIGHT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic [X_W-1:0]   x_cnt;
    logic [X_W-1:0]   x_next;
    logic [Y_W-1:0]   y_cnt;
    logic [Y_W-1:0]   y_next;
    logic [PIX_W-1:0] pixel_in;
    logic [PIX_W-1:0] head_next;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // The output registers are loaded with the head of the FIFO as it will be after this edge,
    // so a pixel written into an empty FIFO must bypass the memory.
    always_comb begin
        pixel_in    = {iRed, iGreen, iBlue};
        full        = (level == LVL_FULL);
        pop         = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
        push        = valid & (~full | pop);
        drop        = valid & full & ~pop;
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase

        x_next = x_cnt;
        y_next = y_cnt;
        if (pop) begin
            if (x_cnt == X_LAST) begin
                x_next = '0;
                y_next = (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
            end else begin
                x_next = x_cnt + X_W'(1);
            end
        end

        head_next = (push && (wr_ptr == rd_ptr_next)) ? pixel_in : mem[rd_ptr_next];
    end

    always_ff @(posedge pixclk) begin
        if (push) begin
            mem[wr_ptr] <= pixel_in;
        end
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= '0;
            x_cnt              <= '0;
            y_cnt              <= '0;
            m_axis_s2mm_tvalid <= 1'b0;
            m_axis_s2mm_tdata  <= '0;
            m_axis_s2mm_tuser  <= 1'b0;
            m_axis_s2mm_tlast  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            x_cnt  <= x_next;
            y_cnt  <= y_next;

            m_axis_s2mm_tvalid <= (level_next != '0);
            if (level_next != '0) begin
                m_axis_s2mm_tdata <= DATA_W'(head_next);
                m_axis_s2mm_tuser <= (x_next == '0) && (y_next == '0);
                m_axis_s2mm_tlast <= (x_next == X_LAST);
            end else begin
                m_axis_s2mm_tdata <= '0;
                m_axis_s2mm_tuser <= 1'b0;
                m_axis_s2mm_tlast <= 1'b0;
            end
        end
    end

    // A drop coinciding with a clear restarts the count at one rather than being lost.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_rgb_axis_s2mm_packer.sv
// Self-checking bench for rgb_axis_s2mm_packer: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rgb_axis_s2mm_packer;

    localparam int COLOR_W    = 8;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int IMG_WIDTH  = 4;
    localparam int IMG_HEIGHT = 2;

    logic                pixclk = 1'b0;
    logic                reset;
    logic                valid;
    logic [COLOR_W-1:0]  iRed;
    logic [COLOR_W-1:0]  iGreen;
    logic [COLOR_W-1:0]  iBlue;
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic                tuser;
    logic                tlast;
    logic                clear_overflow;
    logic [4:0]          fifo_level;
    logic                overflow;
    logic [15:0]         drop_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    rgb_axis_s2mm_packer #(
        .COLOR_W(COLOR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)
    ) dut (
        .pixclk(pixclk), .reset(reset), .valid(valid),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .m_axis_s2mm_tvalid(tvalid), .m_axis_s2mm_tready(tready),
        .m_axis_s2mm_tdata(tdata), .m_axis_s2mm_tuser(tuser), .m_axis_s2mm_tlast(tlast),
        .clear_overflow(clear_overflow), .fifo_level(fifo_level),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 pixclk = ~pixclk;

    // Reference model: a pixel queue, a running count of popped beats, and overflow bookkeeping.
    logic [23:0] mq[$];
    int          m_beats;
    logic        m_ovf;
    int          m_drops;

    typedef struct {
        logic        v;
        logic [23:0] px;
        logic        rdy;
        logic        clr;
        logic        e_tvalid;
        logic [31:0] e_tdata;
        logic        e_tuser;
        logic        e_tlast;
        int          e_level;
        logic        e_ovf;
        int          e_drops;
    } vec_t;

    vec_t vecs[10];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_beats = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic modelStep(input logic v, input logic [23:0] px, input logic rdy, input logic clr);
        bit do_pop;
        bit do_drop;
        do_pop  = (mq.size() > 0) && rdy;
        do_drop = v && (mq.size() == FIFO_DEPTH) && !do_pop;
        if (do_pop) begin
            void'(mq.pop_front());
            m_beats++;
        end
        if (v && !do_drop) mq.push_back(px);
        if (clr) begin
            m_ovf   = do_drop;
            m_drops = do_drop ? 1 : 0;
        end else if (do_drop) begin
            m_ovf   = 1'b1;
            m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] px, input logic rdy, input logic clr);
        valid          = v;
        {iRed, iGreen, iBlue} = px;
        tready         = rdy;
        clear_overflow = clr;
        modelStep(v, px, rdy, clr);
        @(posedge pixclk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        bit ne;
        ne = (mq.size() > 0);
        compare({tag, ".tvalid"}, 32'(tvalid), 32'(ne));
        compare({tag, ".tdata"}, tdata, ne ? {8'h00, mq[0]} : 32'h0);
        compare({tag, ".tuser"}, 32'(tuser), 32'(ne && (m_beats % (IMG_WIDTH * IMG_HEIGHT)) == 0));
        compare({tag, ".tlast"}, 32'(tlast), 32'(ne && (m_beats % IMG_WIDTH) == IMG_WIDTH - 1));
        compare({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
        compare({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        compare({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
    endtask

    task automatic doReset();
        reset          = 1'b1;
        valid          = 1'b0;
        tready         = 1'b0;
        clear_overflow = 1'b0;
        {iRed, iGreen, iBlue} = 24'h0;
        modelReset();
        @(posedge pixclk);
        #1;
        @(posedge pixclk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
            applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
            checkOutput("drain");
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] order[$];

        vecs[0] = '{1'b1, 24'h123456, 1'b1, 1'b0, 1'b1, 32'h00123456, 1'b1, 1'b0, 1, 1'b0, 0};
        vecs[1] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[2] = '{1'b1, 24'hAABBCC, 1'b0, 1'b0, 1'b1, 32'h00AABBCC, 1'b0, 1'b0, 1, 1'b0, 0};
        vecs[3] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 32'h00AABBCC, 1'b0, 1'b0, 1, 1'b0, 0};
        vecs[4] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[5] = '{1'b1, 24'h010203, 1'b1, 1'b0, 1'b1, 32'h00010203, 1'b0, 1'b0, 1, 1'b0, 0};
        vecs[6] = '{1'b1, 24'h040506, 1'b1, 1'b0, 1'b1, 32'h00040506, 1'b0, 1'b1, 1, 1'b0, 0};
        vecs[7] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[8] = '{1'b1, 24'h070809, 1'b0, 1'b0, 1'b1, 32'h00070809, 1'b0, 1'b0, 1, 1'b0, 0};
        vecs[9] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 0, 1'b0, 0};

        doReset();
        compare("reset.tvalid", 32'(tvalid), 32'h0);
        compare("reset.tdata", tdata, 32'h0);
        compare("reset.tuser", 32'(tuser), 32'h0);
        compare("reset.tlast", 32'(tlast), 32'h0);
        compare("reset.level", 32'(fifo_level), 32'h0);
        compare("reset.overflow", 32'(overflow), 32'h0);
        compare("reset.drops", 32'(drop_count), 32'h0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].v, vecs[i].px, vecs[i].rdy, vecs[i].clr);
            compare($sformatf("vec%0d.tvalid", i), 32'(tvalid), 32'(vecs[i].e_tvalid));
            compare($sformatf("vec%0d.tdata", i), tdata, vecs[i].e_tdata);
            compare($sformatf("vec%0d.tuser", i), 32'(tuser), 32'(vecs[i].e_tuser));
            compare($sformatf("vec%0d.tlast", i), 32'(tlast), 32'(vecs[i].e_tlast));
            compare($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(vecs[i].e_level));
            compare($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            compare($sformatf("vec%0d.drops", i), 32'(drop_count), 32'(vecs[i].e_drops));
        end

        // Framing: one full frame of back-to-back beats, then the first beat of the next frame.
        doReset();
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 24'hB00000 | 24'(i), 1'b1, 1'b0);
            compare($sformatf("frame%0d.tdata", i), tdata, 32'h00B00000 | 32'(i));
            compare($sformatf("frame%0d.tuser", i), 32'(tuser), 32'(i == 1 || i == 9));
            compare($sformatf("frame%0d.tlast", i), 32'(tlast), 32'(i == 4 || i == 8));
            checkOutput("frame");
        end
        drain();

        // Stall: 20 cycles of input with the sink blocked.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 24'hA00000 | 24'(i), 1'b0, 1'b0);
            compare("stall.tdata", tdata, 32'h00A00000);
            compare("stall.tvalid", 32'(tvalid), 32'h1);
        end
        compare("stall.level", 32'(fifo_level), 32'd16);
        compare("stall.overflow", 32'(overflow), 32'h1);
        compare("stall.drops", 32'(drop_count), 32'd4);
        checkOutput("stall");

        // Full FIFO with a simultaneous push and pop: nothing dropped.
        applyStimulus(1'b1, 24'hA00014, 1'b1, 1'b0);
        compare("fullpop.level", 32'(fifo_level), 32'd16);
        compare("fullpop.drops", 32'(drop_count), 32'd4);
        compare("fullpop.tdata", tdata, 32'h00A00001);

        for (int i = 1; i < 16; i++) order.push_back(24'hA00000 | 24'(i));
        order.push_back(24'hA00014);
        for (int k = 0; k < 16; k++) begin
            compare($sformatf("release%0d.tdata", k), tdata, {8'h00, order[k]});
            applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
            checkOutput("release");
        end
        compare("release.level", 32'(fifo_level), 32'd0);

        // Clear without a drop, then a clear coinciding with a drop.
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        compare("clear.overflow", 32'(overflow), 32'h0);
        compare("clear.drops", 32'(drop_count), 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 24'hC00000 | 24'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 24'hC000FF, 1'b0, 1'b1);
        compare("cleardrop.overflow", 32'(overflow), 32'h1);
        compare("cleardrop.drops", 32'(drop_count), 32'd1);
        compare("cleardrop.level", 32'(fifo_level), 32'd16);
        checkOutput("cleardrop");
        drain();

        // Reset mid-line with x=2 and five entries buffered.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'hD00000 | 24'(i), 1'b1, 1'b0);
        for (int i = 3; i < 7; i++) applyStimulus(1'b1, 24'hD00000 | 24'(i), 1'b0, 1'b0);
        compare("midline.level", 32'(fifo_level), 32'd5);
        checkOutput("midline");
        #2;
        reset = 1'b1;
        #1;
        compare("asyncreset.tvalid", 32'(tvalid), 32'h0);
        compare("asyncreset.level", 32'(fifo_level), 32'h0);
        modelReset();
        valid = 1'b0;
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 24'hE0E0E0, 1'b0, 1'b0);
        compare("postreset.tuser", 32'(tuser), 32'h1);
        compare("postreset.tdata", tdata, 32'h00E0E0E0);
        checkOutput("postreset");
        drain();

        // Randomized traffic with varying sink stall density.
        doReset();
        for (int blk = 0; blk < 20; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 100; c++) begin
                applyStimulus($urandom_range(0, 99) < 80, 24'($urandom),
                              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 199) == 0);
                checkOutput("random");
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
